bus_memory_responder: RTL and testbench
=======================================

// Module: bus_memory_responder
// PURPOSE
//  Responder end of the processor memory interface (addr/wdata/rdata/abort/write/size/prot/trans).
//  Single-port word RAM with byte/halfword/word access and programmable wait states via n_wait.
//  Raises abort on illegal accesses. Sits between the processor core and on-chip RAM.
// PARAMETERS
//  DEPTH       8192          RAM depth in 32-bit words; byte address range 0..DEPTH*4-1
//  N_WAIT      1             wait cycles on non-sequential transfers (0..15)
//  S_WAIT      0             wait cycles on sequential transfers (0..15)
//  PRIV_LIMIT  32'h0000_1000 byte addresses below this are privileged (see CONFIGURATION)
//  INIT_FILE   ""            hex image loaded with $readmemh when non-empty
// PORTS
//  clk      in   1   clock; all state changes on posedge
//  n_reset  in   1   asynchronous active-low reset
//  addr     in   32  byte address, sampled in address phase
//  wdata    in   32  write data, sampled at completion edge
//  rdata    out  32  read data, valid after completion edge
//  abort    out  1   transfer failed; valid alongside rdata
//  n_wait   out  1   low = stretch current transfer; initiator holds addr/control
//  write    in   1   1 = write, 0 = read
//  size     in   2   00 byte, 01 halfword, 10 word, 11 reserved
//  prot     in   2   prot[1]=1 privileged, prot[0]=1 data (0 = opcode fetch)
//  trans    in   2   00 idle, 01 busy, 10 non-sequential, 11 sequential
// BEHAVIOUR
//  Reset: state IDLE, n_wait=1, abort=0, rdata=0, wait counter=0; RAM contents not cleared.
//  FSM IDLE / WAIT / DATA:
//   - Accept: posedge with n_wait=1 and trans[1]=1 latches addr, write, size, prot.
//     Wait count W = N_WAIT (trans=10) or S_WAIT (trans=11).
//   - W>0: go WAIT, n_wait=0 for exactly W cycles, counter decrements each cycle.
//     Inputs are not sampled while n_wait=0.
//   - W=0: go DATA directly.
//   - DATA completes at the next edge (accept edge + W + 1) and does the following:
//     writes RAM (wdata sampled at this edge) or loads rdata; updates abort.
//   - Pipelining: completion edge is also an accept edge if trans[1]=1.
//     Back-to-back zero-wait sequential words complete one per cycle.
//   - trans 00/01: no transfer; FSM goes IDLE after any completion; rdata/abort hold.
//  Abort conditions (any one):
//   - size=11
//   - halfword with addr[0]=1
//   - word with addr[1:0]!=0
//   - addr >= DEPTH*4
//  On abort: RAM unmodified, rdata=0, abort=1 for that data phase.
//  abort clears on the next non-aborting completion.
//  Reads: word = RAM[addr>>2]. Halfword/byte = addressed lane, zero-extended into rdata[15:0]/[7:0].
//  Writes: byte = wdata[7:0] into lane addr[1:0]; halfword = wdata[15:0] into lane addr[1];
//   other lanes preserved.
//  Reset mid-transfer: in-flight transfer discarded (no RAM write); outputs to reset values immediately.
// CONFIGURATION
//  MEM_PROT_EN defined: accesses with prot[1]=0 and addr < PRIV_LIMIT also abort (RAM unmodified, rdata=0).
//  MEM_PROT_EN undefined: prot ignored; no protection abort logic present.
// TESTING
//  1. Reset mid-wait: trans=10 then n_reset=0 during WAIT -> n_wait=1, abort=0, rdata=0 at once; target word unchanged.
//  2. N_WAIT=1 word write: trans=10 write addr 0x10 wdata 0xDEADBEEF.
//     -> n_wait low 1 cycle; read back 0xDEADBEEF.
//  3. S_WAIT=0 sequential reads: trans=10 at 0x0, then trans=11 at 0x4 and 0x8.
//     -> n_wait=0 only on first; rdata 1/cycle thereafter.
//  4. Byte write: 0xAB to 0x13 over word 0x11223344.
//     -> word reads 0xAB223344; byte read 0x13 gives 0x000000AB.
//  5. Aborts: word read 0x2, halfword 0x1, size=11, addr DEPTH*4.
//     -> each abort=1, rdata=0; then valid read clears abort.
//  6. MEM_PROT_EN: prot=00 write 0x100 -> abort=1, RAM unchanged; prot=10 same -> succeeds.
//     Without the macro, both writes succeed.

Source files
------------

// File: rtl/bus_memory_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_memory_responder_if
// Function : Processor memory bus bundle (address/control, data, handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface bus_memory_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        abort;
  logic        n_wait;
  logic        write;
  logic [1:0]  size;
  logic [1:0]  prot;
  logic [1:0]  trans;

  modport master (
    output addr, wdata, write, size, prot, trans,
    input  rdata, abort, n_wait
  );

  modport slave (
    input  addr, wdata, write, size, prot, trans,
    output rdata, abort, n_wait
  );
endinterface
`default_nettype wire

// File: rtl/bus_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_memory_responder
// Function : Word RAM responder with byte/halfword lanes, wait states and abort.
//            Define MEM_PROT_EN to abort unprivileged accesses below PRIV_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module bus_memory_responder #(
  parameter int          DEPTH      = 8192,
  parameter int          N_WAIT     = 1,
  parameter int          S_WAIT     = 0,
`ifdef MEM_PROT_EN
  parameter logic [31:0] PRIV_LIMIT = 32'h0000_1000,
`endif
  parameter string       INIT_FILE  = ""
) (
  input  wire logic             clk,
  input  wire logic             n_reset,
  bus_memory_responder_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] ADDR_END = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        abort_q;
  logic        n_wait_q;
`ifdef MEM_PROT_EN
  logic        priv_q;
`endif

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx_d;
  logic [31:0]   word_d;
  logic [31:0]   rdata_d;
  logic [31:0]   wlane_d;
  logic [3:0]    be_d;
  logic          abort_d;
  logic          we_d;
  logic [3:0]    wait_d;

  always_comb begin
    idx_d   = addr_q[AW+1:2];
    word_d  = mem[idx_d];
    abort_d = (size_q == 2'b11) ||
              (size_q == 2'b01 && addr_q[0]) ||
              (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
              ({1'b0, addr_q} >= ADDR_END);
`ifdef MEM_PROT_EN
    if (!priv_q && addr_q < PRIV_LIMIT) abort_d = 1'b1;
`endif
    // Narrow reads land zero-extended in the low lanes; writes replicate data across lanes
    case (size_q)
      2'b00: begin
        rdata_d = {24'b0, word_d[{addr_q[1:0], 3'b000} +: 8]};
        be_d    = 4'b0001 << addr_q[1:0];
        wlane_d = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        rdata_d = {16'b0, word_d[{addr_q[1], 4'b0000} +: 16]};
        be_d    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_d = {2{bus.wdata[15:0]}};
      end
      default: begin
        rdata_d = word_d;
        be_d    = 4'b1111;
        wlane_d = bus.wdata;
      end
    endcase
    if (abort_d) rdata_d = 32'b0;
    we_d   = (state_q == ST_DATA) && write_q && !abort_d;
    wait_d = bus.trans[0] ? 4'(S_WAIT) : 4'(N_WAIT);
  end

  always_ff @(posedge clk) begin
    if (we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[idx_d][8*b +: 8] <= wlane_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'b0;
      write_q  <= 1'b0;
      size_q   <= 2'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'b0;
      abort_q  <= 1'b0;
      n_wait_q <= 1'b1;
`ifdef MEM_PROT_EN
      priv_q   <= 1'b0;
`endif
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_q  <= ST_DATA;
        n_wait_q <= 1'b1;
      end
    end else begin
      if (state_q == ST_DATA) begin
        abort_q <= abort_d;
        if (abort_d || !write_q) rdata_q <= rdata_d;
      end
      // A completion edge doubles as the next address phase
      if (bus.trans[1]) begin
        addr_q  <= bus.addr;
        write_q <= bus.write;
        size_q  <= bus.size;
`ifdef MEM_PROT_EN
        priv_q  <= bus.prot[1];
`endif
        cnt_q   <= wait_d;
        if (wait_d == 4'd0) begin
          state_q <= ST_DATA;
        end else begin
          state_q  <= ST_WAIT;
          n_wait_q <= 1'b0;
        end
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.abort  = abort_q;
  assign bus.n_wait = n_wait_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_memory_responder
// Function : Directed + random bench against an array-based memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_memory_responder;
  localparam int          DEPTH      = 2048;
  localparam int          N_WAIT     = 1;
  localparam int          S_WAIT     = 0;
  localparam logic [31:0] PRIV_LIMIT = 32'h0000_1000;
`ifdef MEM_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  bus_memory_responder_if bus();

  bus_memory_responder #(
    .DEPTH  (DEPTH),
    .N_WAIT (N_WAIT),
    .S_WAIT (S_WAIT)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata = 32'b0;
  logic        exp_abort = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_abort(input logic [1:0] sz, input logic [1:0] pr, input logic [31:0] a);
    bit ab;
    ab = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
         (a >= 32'(DEPTH * 4));
    ab = ab || (PROT_EN && pr[1] == 1'b0 && a < PRIV_LIMIT);
    return ab;
  endfunction

  task automatic model_apply(input logic w, input logic [1:0] sz, input logic [1:0] pr,
                             input logic [31:0] a, input logic [31:0] wd);
    int unsigned wi;
    int unsigned sh;
    logic [31:0] mask;
    if (is_abort(sz, pr, a)) begin
      exp_abort = 1'b1;
      exp_rdata = 32'b0;
      return;
    end
    exp_abort = 1'b0;
    wi = a / 4;
    case (sz)
      2'd0:    begin sh = 8 * (a % 4);        mask = 32'hFF   << sh; end
      2'd1:    begin sh = 16 * ((a / 2) % 2); mask = 32'hFFFF << sh; end
      default: begin sh = 0;                  mask = 32'hFFFF_FFFF; end
    endcase
    if (w) ref_mem[wi] = (ref_mem[wi] & ~mask) | ((wd << sh) & mask);
    else   exp_rdata   = (ref_mem[wi] & mask) >> sh;
  endtask

  task automatic drive(input logic [1:0] tr, input logic w, input logic [1:0] sz,
                       input logic [1:0] pr, input logic [31:0] a, input logic [31:0] wd);
    bus.trans = tr; bus.write = w; bus.size = sz;
    bus.prot  = pr; bus.addr  = a; bus.wdata = wd;
  endtask

  task automatic xfer(input string tag, input logic [1:0] tr, input logic w, input logic [1:0] sz,
                      input logic [1:0] pr, input logic [31:0] a, input logic [31:0] wd);
    int waits = 0;
    @(negedge clk);
    drive(tr, w, sz, pr, a, wd);
    @(posedge clk); #1;
    bus.trans = 2'b00;
    while (bus.n_wait !== 1'b1 && waits < 32) begin
      @(posedge clk); #1;
      waits++;
    end
    chk({tag, ".waits"}, 32'(waits), tr[0] ? 32'(S_WAIT) : 32'(N_WAIT));
    @(posedge clk); #1;
    model_apply(w, sz, pr, a, wd);
    chk({tag, ".rdata"}, bus.rdata, exp_rdata);
    chk({tag, ".abort"}, {31'b0, bus.abort}, {31'b0, exp_abort});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  sz, pr, tr;
    logic        w;
    logic [31:0] a;
    int          r;

    drive(2'b00, 1'b0, 2'b10, 2'b11, 32'b0, 32'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset.n_wait", {31'b0, bus.n_wait}, 32'd1);
    chk("reset.abort",  {31'b0, bus.abort},  32'd0);
    chk("reset.rdata",  bus.rdata,           32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      xfer("fill", 2'b11, 1'b1, 2'b10, 2'b11, 32'(i * 4), $urandom);

    // Non-sequential word write with one wait state, then read back
    xfer("wr_dead", 2'b10, 1'b1, 2'b10, 2'b11, 32'h10, 32'hDEAD_BEEF);
    xfer("rd_dead", 2'b10, 1'b0, 2'b10, 2'b11, 32'h10, 32'h0);
    chk("rd_dead.value", bus.rdata, 32'hDEAD_BEEF);

    // Pipelined sequential reads: one wait on the first, then one word per cycle
    @(negedge clk);
    drive(2'b10, 1'b0, 2'b10, 2'b11, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("seq.first_wait", {31'b0, bus.n_wait}, 32'd0);
    @(posedge clk); #1;
    chk("seq.data_phase", {31'b0, bus.n_wait}, 32'd1);
    drive(2'b11, 1'b0, 2'b10, 2'b11, 32'h4, 32'h0);
    @(posedge clk); #1;
    model_apply(1'b0, 2'b10, 2'b11, 32'h0, 32'h0);
    chk("seq.rd0", bus.rdata, exp_rdata);
    chk("seq.nw0", {31'b0, bus.n_wait}, 32'd1);
    drive(2'b11, 1'b0, 2'b10, 2'b11, 32'h8, 32'h0);
    @(posedge clk); #1;
    model_apply(1'b0, 2'b10, 2'b11, 32'h4, 32'h0);
    chk("seq.rd4", bus.rdata, exp_rdata);
    chk("seq.nw4", {31'b0, bus.n_wait}, 32'd1);
    bus.trans = 2'b00;
    @(posedge clk); #1;
    model_apply(1'b0, 2'b10, 2'b11, 32'h8, 32'h0);
    chk("seq.rd8", bus.rdata, exp_rdata);

    // Byte lane write over a known word
    xfer("wr_base", 2'b10, 1'b1, 2'b10, 2'b11, 32'h10, 32'h1122_3344);
    xfer("wr_byte", 2'b10, 1'b1, 2'b00, 2'b11, 32'h13, 32'h0000_00AB);
    xfer("rd_word", 2'b10, 1'b0, 2'b10, 2'b11, 32'h10, 32'h0);
    chk("rd_word.value", bus.rdata, 32'hAB22_3344);
    xfer("rd_byte", 2'b10, 1'b0, 2'b00, 2'b11, 32'h13, 32'h0);
    chk("rd_byte.value", bus.rdata, 32'h0000_00AB);

    // Illegal accesses, then a legal read clears abort
    xfer("ab_word",  2'b10, 1'b0, 2'b10, 2'b11, 32'h2, 32'h0);
    xfer("ab_half",  2'b10, 1'b0, 2'b01, 2'b11, 32'h1, 32'h0);
    xfer("ab_size",  2'b10, 1'b0, 2'b11, 2'b11, 32'h20, 32'h0);
    xfer("ab_range", 2'b10, 1'b0, 2'b10, 2'b11, 32'(DEPTH * 4), 32'h0);
    xfer("ab_wr",    2'b10, 1'b1, 2'b10, 2'b11, 32'h22, 32'hFFFF_FFFF);
    xfer("ab_clear", 2'b10, 1'b0, 2'b10, 2'b11, 32'h20, 32'h0);

    // Unprivileged then privileged write below the limit
    xfer("prot_u_wr", 2'b10, 1'b1, 2'b10, 2'b00, 32'h100, 32'hCAFE_F00D);
    xfer("prot_u_rd", 2'b10, 1'b0, 2'b10, 2'b11, 32'h100, 32'h0);
    xfer("prot_p_wr", 2'b10, 1'b1, 2'b10, 2'b10, 32'h100, 32'h1234_5678);
    xfer("prot_p_rd", 2'b10, 1'b0, 2'b10, 2'b11, 32'h100, 32'h0);
    chk("prot_p_rd.value", bus.rdata, 32'h1234_5678);

    // Reset during the wait state discards the in-flight write
    xfer("rst_pre_wr", 2'b10, 1'b1, 2'b10, 2'b11, 32'h40, 32'h5A5A_5A5A);
    xfer("rst_pre_rd", 2'b10, 1'b0, 2'b10, 2'b11, 32'h40, 32'h0);
    @(negedge clk);
    drive(2'b10, 1'b1, 2'b10, 2'b11, 32'h40, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("rst.in_wait", {31'b0, bus.n_wait}, 32'd0);
    n_reset = 1'b0;
    #1;
    exp_rdata = 32'b0;
    exp_abort = 1'b0;
    chk("rst.n_wait", {31'b0, bus.n_wait}, 32'd1);
    chk("rst.abort",  {31'b0, bus.abort},  32'd0);
    chk("rst.rdata",  bus.rdata,           32'd0);
    bus.trans = 2'b00;
    @(negedge clk);
    n_reset = 1'b1;
    xfer("rst_post_rd", 2'b10, 1'b0, 2'b10, 2'b11, 32'h40, 32'h0);
    chk("rst_post_rd.value", bus.rdata, 32'h5A5A_5A5A);

    for (int i = 0; i < 250; i++) begin
      sz = 2'($urandom_range(0, 3));
      pr = 2'($urandom_range(0, 3));
      tr = 2'($urandom_range(2, 3));
      w  = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else        a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if (r < 7 && sz == 2'd2) a[1:0] = 2'b00;
      if (r < 7 && sz == 2'd1) a[0]   = 1'b0;
      xfer("rand", tr, w, sz, pr, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
